// File: rtl/ccw_output_ctrl_if.sv
// Bundle of the ccw output controller's arbitration inputs, grant pulses and
// downstream link signals.
//   master : the controller (drives grants and the ccw link)
//   slave  : the surroundings (ccw input stage, PE injection, downstream router)
interface ccw_output_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  polarity;
  logic                  request_ccw_even;
  logic                  request_ccw_odd;
  logic                  request_pe_even;
  logic                  request_pe_odd;
  logic [DATA_WIDTH-1:0] data_in_ccw_even;
  logic [DATA_WIDTH-1:0] data_in_ccw_odd;
  logic [DATA_WIDTH-1:0] data_in_pe_even;
  logic [DATA_WIDTH-1:0] data_in_pe_odd;
  logic                  grant_ccw_even;
  logic                  grant_ccw_odd;
  logic                  grant_pe_even;
  logic                  grant_pe_odd;
  logic                  ccwro;
  logic                  ccwso;
  logic [DATA_WIDTH-1:0] ccwdo;

  modport master (
    input  polarity,
    input  request_ccw_even, request_ccw_odd, request_pe_even, request_pe_odd,
    input  data_in_ccw_even, data_in_ccw_odd, data_in_pe_even, data_in_pe_odd,
    input  ccwro,
    output grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd,
    output ccwso, ccwdo
  );

  modport slave (
    output polarity,
    output request_ccw_even, request_ccw_odd, request_pe_even, request_pe_odd,
    output data_in_ccw_even, data_in_ccw_odd, data_in_pe_even, data_in_pe_odd,
    output ccwro,
    input  grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd,
    input  ccwso, ccwdo
  );
endinterface

// File: rtl/ccw_output_ctrl.sv
// Counter-clockwise output port controller of the ring router.
// Two single-entry VC buffers (even/odd). polarity selects which VC fills
// (round-robin between the ccw input stage and PE injection) while the other
// drains onto the ccw link under ccwro.
// Optional build macro CCW_OUT_HOP_DEC_EN: decrement the hop field [55:48]
// (mod 256) on the way out; undefined means data passes unchanged.
// DATA_WIDTH must be at least 56 since the hop field sits at [55:48].
//
// Per-VC buffer states:
//   valid_q | meaning
//   0       | empty, may capture a winner in its fill phase
//   1       | holding a packet, waits for its drain phase with ccwro=1
module ccw_output_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input logic                clk,
  input logic                rst,
  ccw_output_ctrl_if.master  bus
);

  typedef enum logic {SRC_CCW = 1'b0, SRC_PE = 1'b1} src_e;

  logic [DATA_WIDTH-1:0] buf_even_q, buf_even_d;
  logic [DATA_WIDTH-1:0] buf_odd_q, buf_odd_d;
  logic                  valid_even_q, valid_even_d;
  logic                  valid_odd_q, valid_odd_d;
  src_e                  prio_even_q, prio_even_d;
  src_e                  prio_odd_q, prio_odd_d;
  logic                  grant_ccw_even_q, grant_ccw_even_d;
  logic                  grant_ccw_odd_q, grant_ccw_odd_d;
  logic                  grant_pe_even_q, grant_pe_even_d;
  logic                  grant_pe_odd_q, grant_pe_odd_d;
  logic                  ccwso_q, ccwso_d;
  logic [DATA_WIDTH-1:0] ccwdo_q, ccwdo_d;

  logic fill_even, fill_odd;
  logic win_ccw_even, win_pe_even, win_ccw_odd, win_pe_odd;
  logic drain_even, drain_odd;

  // Outgoing packet view; the hop decrement is the only in-flight edit.
  function automatic logic [DATA_WIDTH-1:0] hop_proc(input logic [DATA_WIDTH-1:0] pkt);
    logic [DATA_WIDTH-1:0] res;
    res = pkt;
`ifdef CCW_OUT_HOP_DEC_EN
    res[55:48] = pkt[55:48] - 8'd1;
`endif
    return res;
  endfunction

  // Arbitration, buffer update and link launch decisions for both VCs.
  always_comb begin
    // Fill only in the VC's own phase and only into an empty buffer, so a
    // request lingering after its grant is never granted twice.
    fill_even = ~bus.polarity & ~valid_even_q;
    fill_odd  =  bus.polarity & ~valid_odd_q;

    win_ccw_even = fill_even & bus.request_ccw_even &
                   (~bus.request_pe_even | (prio_even_q == SRC_CCW));
    win_pe_even  = fill_even & bus.request_pe_even &
                   (~bus.request_ccw_even | (prio_even_q == SRC_PE));
    win_ccw_odd  = fill_odd & bus.request_ccw_odd &
                   (~bus.request_pe_odd | (prio_odd_q == SRC_CCW));
    win_pe_odd   = fill_odd & bus.request_pe_odd &
                   (~bus.request_ccw_odd | (prio_odd_q == SRC_PE));

    drain_even =  bus.polarity & valid_even_q & bus.ccwro;
    drain_odd  = ~bus.polarity & valid_odd_q & bus.ccwro;

    buf_even_d   = buf_even_q;
    buf_odd_d    = buf_odd_q;
    valid_even_d = valid_even_q;
    valid_odd_d  = valid_odd_q;
    prio_even_d  = prio_even_q;
    prio_odd_d   = prio_odd_q;

    if (win_ccw_even) buf_even_d = bus.data_in_ccw_even;
    if (win_pe_even)  buf_even_d = bus.data_in_pe_even;
    if (win_ccw_odd)  buf_odd_d  = bus.data_in_ccw_odd;
    if (win_pe_odd)   buf_odd_d  = bus.data_in_pe_odd;

    // Fill and drain of one VC live in opposite phases, so these never clash.
    if (win_ccw_even | win_pe_even) valid_even_d = 1'b1;
    else if (drain_even)            valid_even_d = 1'b0;
    if (win_ccw_odd | win_pe_odd)   valid_odd_d  = 1'b1;
    else if (drain_odd)             valid_odd_d  = 1'b0;

    // Priority only rotates on a real contest; a lone requester leaves it.
    if (fill_even & bus.request_ccw_even & bus.request_pe_even)
      prio_even_d = (prio_even_q == SRC_CCW) ? SRC_PE : SRC_CCW;
    if (fill_odd & bus.request_ccw_odd & bus.request_pe_odd)
      prio_odd_d = (prio_odd_q == SRC_CCW) ? SRC_PE : SRC_CCW;

    grant_ccw_even_d = win_ccw_even;
    grant_pe_even_d  = win_pe_even;
    grant_ccw_odd_d  = win_ccw_odd;
    grant_pe_odd_d   = win_pe_odd;

    ccwso_d = drain_even | drain_odd;
    ccwdo_d = ccwdo_q;
    if (drain_even)     ccwdo_d = hop_proc(buf_even_q);
    else if (drain_odd) ccwdo_d = hop_proc(buf_odd_q);
  end

  // State and registered outputs; reset discards any buffered packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_even_q       <= '0;
      buf_odd_q        <= '0;
      valid_even_q     <= 1'b0;
      valid_odd_q      <= 1'b0;
      prio_even_q      <= SRC_CCW;
      prio_odd_q       <= SRC_CCW;
      grant_ccw_even_q <= 1'b0;
      grant_ccw_odd_q  <= 1'b0;
      grant_pe_even_q  <= 1'b0;
      grant_pe_odd_q   <= 1'b0;
      ccwso_q          <= 1'b0;
      ccwdo_q          <= '0;
    end else begin
      buf_even_q       <= buf_even_d;
      buf_odd_q        <= buf_odd_d;
      valid_even_q     <= valid_even_d;
      valid_odd_q      <= valid_odd_d;
      prio_even_q      <= prio_even_d;
      prio_odd_q       <= prio_odd_d;
      grant_ccw_even_q <= grant_ccw_even_d;
      grant_ccw_odd_q  <= grant_ccw_odd_d;
      grant_pe_even_q  <= grant_pe_even_d;
      grant_pe_odd_q   <= grant_pe_odd_d;
      ccwso_q          <= ccwso_d;
      ccwdo_q          <= ccwdo_d;
    end
  end

  assign bus.grant_ccw_even = grant_ccw_even_q;
  assign bus.grant_ccw_odd  = grant_ccw_odd_q;
  assign bus.grant_pe_even  = grant_pe_even_q;
  assign bus.grant_pe_odd   = grant_pe_odd_q;
  assign bus.ccwso          = ccwso_q;
  assign bus.ccwdo          = ccwdo_q;

endmodule

// File: tb/tb_ccw_output_ctrl.sv
// Directed bench for ccw_output_ctrl: a per-cycle vector table covering the
// single packet, round-robin, back-pressure, wrong-phase and fill/drain
// overlap cases, plus hand-written reset sequences.
module tb_ccw_output_ctrl;

  localparam int DW = 64;

  localparam logic [DW-1:0] D_CE = 64'h0005_0000_0000_0011;
  localparam logic [DW-1:0] D_CO = 64'h0003_0000_0000_00AA;
  localparam logic [DW-1:0] D_PE = 64'h0007_0000_0000_0022;
  localparam logic [DW-1:0] D_PO = 64'h0009_0000_0000_0033;

  // in = {polarity, req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd, ccwro}
  // g  = {grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd}
  typedef struct {
    logic [5:0]    in;
    logic [3:0]    g;
    logic          so;
    logic [DW-1:0] d;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ccw_output_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ccw_output_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_hop(input logic [DW-1:0] pkt);
    logic [DW-1:0] r;
    r = pkt;
`ifdef CCW_OUT_HOP_DEC_EN
    r[55:48] = pkt[55:48] - 8'd1;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    bus.polarity         = in[5];
    bus.request_ccw_even = in[4];
    bus.request_ccw_odd  = in[3];
    bus.request_pe_even  = in[2];
    bus.request_pe_odd   = in[1];
    bus.ccwro            = in[0];
  endtask

  function automatic logic [3:0] grants();
    return {bus.grant_ccw_even, bus.grant_ccw_odd, bus.grant_pe_even, bus.grant_pe_odd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t          vecs[$];
  logic [DW-1:0] h_ce, h_co, h_pe, h_po;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    h_ce = exp_hop(D_CE);
    h_co = exp_hop(D_CO);
    h_pe = exp_hop(D_PE);
    h_po = exp_hop(D_PO);

    bus.data_in_ccw_even = D_CE;
    bus.data_in_ccw_odd  = D_CO;
    bus.data_in_pe_even  = D_PE;
    bus.data_in_pe_odd   = D_PO;

    // single odd packet
    vecs.push_back('{6'b101000, 4'b0100, 1'b0, 64'h0});
    vecs.push_back('{6'b100000, 4'b0000, 1'b0, 64'h0});
    vecs.push_back('{6'b000001, 4'b0000, 1'b1, h_co});
    vecs.push_back('{6'b000001, 4'b0000, 1'b0, h_co});
    // round-robin on even: ccw, pe, ccw
    vecs.push_back('{6'b010100, 4'b1000, 1'b0, h_co});
    vecs.push_back('{6'b110101, 4'b0000, 1'b1, h_ce});
    vecs.push_back('{6'b010100, 4'b0010, 1'b0, h_ce});
    vecs.push_back('{6'b110101, 4'b0000, 1'b1, h_pe});
    vecs.push_back('{6'b010100, 4'b1000, 1'b0, h_pe});
    vecs.push_back('{6'b110101, 4'b0000, 1'b1, h_ce});
    // back-pressure: even full, ccwro low for 6 cycles
    vecs.push_back('{6'b010100, 4'b0010, 1'b0, h_ce});
    vecs.push_back('{6'b110100, 4'b0000, 1'b0, h_ce});
    vecs.push_back('{6'b010100, 4'b0000, 1'b0, h_ce});
    vecs.push_back('{6'b110100, 4'b0000, 1'b0, h_ce});
    vecs.push_back('{6'b010100, 4'b0000, 1'b0, h_ce});
    vecs.push_back('{6'b110100, 4'b0000, 1'b0, h_ce});
    vecs.push_back('{6'b010100, 4'b0000, 1'b0, h_ce});
    vecs.push_back('{6'b110101, 4'b0000, 1'b1, h_pe});
    vecs.push_back('{6'b110101, 4'b0000, 1'b0, h_pe});
    // wrong phase, then lingering request after grant
    vecs.push_back('{6'b110000, 4'b0000, 1'b0, h_pe});
    vecs.push_back('{6'b110000, 4'b0000, 1'b0, h_pe});
    vecs.push_back('{6'b010000, 4'b1000, 1'b0, h_pe});
    vecs.push_back('{6'b010000, 4'b0000, 1'b0, h_pe});
    // odd fill concurrent with even drain, odd round-robin
    vecs.push_back('{6'b101011, 4'b0100, 1'b1, h_ce});
    vecs.push_back('{6'b001011, 4'b0000, 1'b1, h_co});
    vecs.push_back('{6'b101010, 4'b0001, 1'b0, h_co});
    vecs.push_back('{6'b000001, 4'b0000, 1'b1, h_po});
    vecs.push_back('{6'b000000, 4'b0000, 1'b0, h_po});

    // Reset with every request high
    rst = 1'b1;
    drive(6'b011111);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("rst%0d grants", i), {60'h0, grants()}, 64'h0);
      chk($sformatf("rst%0d ccwso", i), {63'h0, bus.ccwso}, 64'h0);
      chk($sformatf("rst%0d ccwdo", i), bus.ccwdo, 64'h0);
    end
    rst = 1'b0;
    drive(6'b000000);
    step();
    chk("post_rst grants", {60'h0, grants()}, 64'h0);
    chk("post_rst ccwso", {63'h0, bus.ccwso}, 64'h0);
    chk("post_rst ccwdo", bus.ccwdo, 64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      step();
      chk($sformatf("v%0d grants", i), {60'h0, grants()}, {60'h0, vecs[i].g});
      chk($sformatf("v%0d ccwso", i), {63'h0, bus.ccwso}, {63'h0, vecs[i].so});
      chk($sformatf("v%0d ccwdo", i), bus.ccwdo, vecs[i].d);
    end

    // Reset mid-operation: buffered even packet is discarded
    drive(6'b010000);
    step();
    chk("mid capture grant", {60'h0, grants()}, 64'h8);
    drive(6'b100001);
    rst = 1'b1;
    step();
    chk("mid rst grants", {60'h0, grants()}, 64'h0);
    chk("mid rst ccwso", {63'h0, bus.ccwso}, 64'h0);
    chk("mid rst ccwdo", bus.ccwdo, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i == 0 ? 6'b100001 : 6'b000001);
      step();
      chk($sformatf("mid post%0d ccwso", i), {63'h0, bus.ccwso}, 64'h0);
      chk($sformatf("mid post%0d ccwdo", i), bus.ccwdo, 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccw_output_ctrl.md
# ccw_output_ctrl

Counter-clockwise output-port controller of the ring router, directly downstream of the ccw input stage. It arbitrates between the ccw input buffer and the PE injection input for each virtual channel (even/odd), holds one packet per VC, and launches it onto the ccw link (`ccwso`/`ccwdo`) under the downstream ready handshake. It alternates buffer fill and link drain per VC using `polarity`. It optionally decrements the hop field in flight.

## Interface
- `DATA_WIDTH`, default 64: packet width. Must be ≥ 56 because the hop field occupies bits [55:48].
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `polarity` input 1: global phase.
  - 0: even VC fills, odd VC drains.
  - 1: odd VC fills, even VC drains.
- `request_ccw_even`, `request_ccw_odd` input 1 each: requests from the ccw input stage.
- `request_pe_even`, `request_pe_odd` input 1 each: requests from the PE injection input.
- `data_in_ccw_even`, `data_in_ccw_odd`, `data_in_pe_even`, `data_in_pe_odd` input DATA_WIDTH each: packet data valid while the matching request is high.
- `grant_ccw_even`, `grant_ccw_odd`, `grant_pe_even`, `grant_pe_odd` output 1 each: registered one-cycle grant pulses.
- `ccwro` input 1: downstream ready.
- `ccwso` output 1: link send strobe, registered.
- `ccwdo` output DATA_WIDTH: link data, registered.

## Operation
- **Storage:** two single-entry buffers, `buf_even` and `buf_odd`, each with a valid flag.
- **Fill of VC v:**
  - Allowed only in cycles where that VC fills (even when `polarity`=0, odd when `polarity`=1) and `valid_v`=0.
  - If any request for v is high in such a cycle, one source wins. At the clock edge the winner's data is written to `buf_v`, `valid_v` is set, and the winner's grant register is set.
- **Arbitration:** per-VC round-robin between ccw and pe.
  - A lone requester wins.
  - When both request, the source named by the priority bit `prio_v` wins, and `prio_v` flips to the other source.
  - `prio_v` resets to ccw.
- **Grants:** high for exactly the cycle after capture, then cleared. A grant never asserts for a request seen in the wrong polarity phase or while `valid_v`=1.
- **Drain of VC v:**
  - Occurs in the opposite phase: even drains when `polarity`=1, odd when `polarity`=0.
  - Requires `valid_v`=1 and `ccwro`=1 sampled in that cycle.
  - At the edge: `ccwso`<=1, `ccwdo`<=processed `buf_v`, `valid_v`<=0.
  - Otherwise `ccwso`<=0 and `ccwdo` holds its last value.
- **Fill/drain exclusivity:** fill and drain of the same VC never coincide, because they occur in opposite phases. In any cycle at most one VC fills and the other may drain.
- **Full buffer:** while `ccwro`=0 the packet stays buffered, and no grant is issued for that VC.
- **Reset mid-operation:** buffered packets are discarded, grants drop, and `ccwso` drops on the next edge.

## Timing
- **Reset values:** `ccwso`=0, `ccwdo`=0, all grants 0, `valid_even`=`valid_odd`=0, `prio_even`=`prio_odd`=ccw.
- **Request to grant:** 1 cycle. The request is sampled in cycle T and the grant is high in T+1.
- **Input handshake:** the input stage must drop its request in response to the grant. A request still high in T+1 is ignored, since the buffer is full.
- **Capture to link:**
  - Minimum 1 cycle, i.e. the next phase flip.
  - `ccwso` goes high in the cycle after the drain-phase cycle in which `ccwro`=1 was sampled.
- **Throughput:** at most one packet per VC per two phases. `ccwso` is a single-cycle pulse per packet.

## Configuration
- **`CCW_OUT_HOP_DEC_EN` defined:** on drain, `ccwdo`[55:48] = `buf_v`[55:48] − 1, modulo 256. All other bits pass unchanged.
- **`CCW_OUT_HOP_DEC_EN` undefined:** `ccwdo` = `buf_v` unmodified.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all requests high → `ccwso`=0, `ccwdo`=0, all grants 0 throughout and one cycle after release.
- **Single odd packet:** `polarity`=1, `request_ccw_odd`=1, `data_in_ccw_odd`=0x0003_0000_0000_00AA (hop=3) → `grant_ccw_odd` pulses 1 cycle. Then `polarity`=0 with `ccwro`=1 → `ccwso` high 1 cycle, `ccwdo`=0x0002_0000_0000_00AA with the macro on.
- **Round-robin:** `polarity`=0, `request_ccw_even` and `request_pe_even` both held; drain each packet in the next `polarity`=1 phase → grant order is ccw, pe, ccw, with matching `ccwdo` payloads.
- **Back-pressure:** `ccwro`=0 for 6 cycles with `buf_even` full → `ccwso` stays 0 and no even grants despite requests. With `ccwro`=1 → exactly one `ccwso` pulse.
- **Wrong phase:** `request_ccw_even`=1 while `polarity`=1 → no grant until `polarity` returns to 0.
- **Macro off:** build without `CCW_OUT_HOP_DEC_EN`, then repeat the single odd packet scenario → `ccwdo`=0x0003_0000_0000_00AA.
